// File: rtl/ctrl_pkg.sv
// Shared decode-stage definitions: opcode map, control-word field positions, FSM states.
package ctrl_pkg;

    localparam int unsigned NFLAGS = 7;
    localparam int unsigned NTAIL  = 3;

    localparam int unsigned OP_ADD  = 'h00;
    localparam int unsigned OP_SUB  = 'h01;
    localparam int unsigned OP_MUL  = 'h02;
    localparam int unsigned OP_LDB  = 'h0A;
    localparam int unsigned OP_LDW  = 'h0B;
    localparam int unsigned OP_STB  = 'h0C;
    localparam int unsigned OP_STW  = 'h0D;
    localparam int unsigned OP_BEQ  = 'h1E;
    localparam int unsigned OP_JUMP = 'h1F;

    // Bit positions inside the flag group (MSB side of the control word)
    localparam int unsigned F_REGWRITE = 0;
    localparam int unsigned F_ALUSRC   = 1;
    localparam int unsigned F_MEMWRITE = 2;
    localparam int unsigned F_MEMTOREG = 3;
    localparam int unsigned F_MEMREAD  = 4;
    localparam int unsigned F_BRANCH   = 5;
    localparam int unsigned F_REGDST   = 6;

    // Bit positions inside the tail group (LSB side of the control word)
    localparam int unsigned T_WORD = 0;
    localparam int unsigned T_BYTE = 1;
    localparam int unsigned T_JUMP = 2;

    typedef enum logic {
        RUN     = 1'b0,
        MULBUSY = 1'b1
    } ctrlStateT;

    // Control word = {7 flags, opcode, jump/byte/word}
    function automatic int unsigned cwWidth(input int unsigned opw);
        return opw + NFLAGS + NTAIL;
    endfunction

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational opcode decoder; unknown opcodes yield an all-zero word and flag illegal.
module ctrl_decode_comb
    import ctrl_pkg::*;
#(
    parameter int unsigned OPW = 6
) (
    input  logic [OPW-1:0]            opcode,
    output logic [cwWidth(OPW)-1:0]   controlWord,
    output logic                      illegal
);

    logic [NFLAGS-1:0] flags;
    logic [NTAIL-1:0]  tail;

    always_comb begin
        flags   = '0;
        tail    = '0;
        illegal = 1'b0;
        case (opcode)
            OPW'(OP_ADD), OPW'(OP_SUB), OPW'(OP_MUL): begin
                flags[F_REGDST]   = 1'b1;
                flags[F_REGWRITE] = 1'b1;
            end
            OPW'(OP_LDB), OPW'(OP_LDW): begin
                flags[F_MEMREAD]  = 1'b1;
                flags[F_MEMTOREG] = 1'b1;
                flags[F_ALUSRC]   = 1'b1;
                flags[F_REGWRITE] = 1'b1;
                if (opcode == OPW'(OP_LDB)) tail[T_BYTE] = 1'b1;
                else                        tail[T_WORD] = 1'b1;
            end
            OPW'(OP_STB), OPW'(OP_STW): begin
                flags[F_MEMWRITE] = 1'b1;
                flags[F_ALUSRC]   = 1'b1;
                if (opcode == OPW'(OP_STB)) tail[T_BYTE] = 1'b1;
                else                        tail[T_WORD] = 1'b1;
            end
            OPW'(OP_BEQ):  flags[F_BRANCH] = 1'b1;
            OPW'(OP_JUMP): tail[T_JUMP]    = 1'b1;
            default:       illegal         = 1'b1;
        endcase
        controlWord = illegal ? '0 : {flags, opcode, tail};
    end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Registered decode stage: opcode decode into ID/EX with handshake, load-use interlock,
// multi-cycle MUL issue hold, flush on taken branch/jump and illegal-opcode pulse.
module decode_ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int unsigned OPW       = 6,
    parameter int unsigned REGW      = 5,
    parameter int unsigned MUL_LAT   = 4,
    parameter bit          HAZARD_EN = 1'b1,
    localparam int unsigned CW       = cwWidth(OPW)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inValid,
    output logic            inReady,
    input  logic [OPW-1:0]  opcode,
    input  logic [REGW-1:0] rs,
    input  logic [REGW-1:0] rt,
    input  logic [REGW-1:0] rd,
    input  logic            flush,
    input  logic            exValid,
    input  logic            exMemRead,
    input  logic [REGW-1:0] exDestReg,
    input  logic            outReady,
    output logic            outValid,
    output logic [CW-1:0]   controlBits,
    output logic [REGW-1:0] destReg,
    output logic            illegal,
    output logic            busy
);

    localparam int unsigned CNTW     = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
    localparam int unsigned MUL_INIT = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;

    ctrlStateT       state;
    logic [CNTW-1:0] mulCnt;
    logic [CW-1:0]   decWord;
    logic            decIllegal;
    logic            hazardStall;
    logic            accept;
    logic            isMul;

    ctrl_decode_comb #(.OPW(OPW)) uDecode (
        .opcode      (opcode),
        .controlWord (decWord),
        .illegal     (decIllegal)
    );

    // Load in EX feeding a source of this instruction must wait one cycle; r0 never aliases
    assign hazardStall = HAZARD_EN && exValid && exMemRead && (exDestReg != '0)
                         && ((exDestReg == rs) || (exDestReg == rt));
    assign inReady     = (state == RUN) && !hazardStall && (!outValid || outReady);
    assign accept      = inValid && inReady && !flush;
    assign isMul       = (opcode == OPW'(OP_MUL));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            mulCnt      <= '0;
            busy        <= 1'b0;
            outValid    <= 1'b0;
            controlBits <= '0;
            destReg     <= '0;
            illegal     <= 1'b0;
        end else if (flush) begin
            state    <= RUN;
            mulCnt   <= '0;
            busy     <= 1'b0;
            outValid <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            illegal <= 1'b0;
            if (accept) begin
                if (decIllegal) begin
                    outValid    <= 1'b0;
                    controlBits <= '0;
                    destReg     <= '0;
                    illegal     <= 1'b1;
                end else begin
                    outValid    <= 1'b1;
                    controlBits <= decWord;
                    destReg     <= decWord[CW-1] ? rd : rt;
                end
            end else if (outReady) begin
                outValid <= 1'b0;
            end

            // MUL occupies EX for MUL_LAT cycles; block issue for the remaining MUL_LAT-1
            case (state)
                RUN: begin
                    if (accept && isMul && (MUL_LAT > 1)) begin
                        state  <= MULBUSY;
                        busy   <= 1'b1;
                        mulCnt <= CNTW'(MUL_INIT);
                    end
                end
                MULBUSY: begin
                    if (mulCnt == '0) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end else begin
                        mulCnt <= mulCnt - CNTW'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule
